// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: fetch packet type and sizing shared by fetch, the instruction queue and decode
package inst_queue_pkg;
    localparam int ID_WIDTH     = 2;
    localparam int XLEN         = 32;
    localparam int IQ_DEPTH_DEF = 8;
    typedef struct packed {
        logic [ID_WIDTH-1:0]           valid;
        logic [ID_WIDTH-1:0][XLEN-1:0] inst;
        logic [XLEN-1:0]               pc;
        logic [ID_WIDTH-1:0]           predict_taken;
        logic [ID_WIDTH-1:0][XLEN-1:0] predict_target;
    } fetch_packet_t;
endpackage

// File: rtl/inst_queue_if.sv
// inst_queue_if: push (fetch) and pop (decode) handshakes plus occupancy of the instruction queue
interface inst_queue_if
    import inst_queue_pkg::*;
#(
    parameter int IQ_DEPTH = IQ_DEPTH_DEF
);
    localparam int IQ_IDX = $clog2(IQ_DEPTH);
    logic          in_valid;
    logic          in_ready;
    fetch_packet_t in_packet;
    logic          out_valid;
    logic          out_ready;
    fetch_packet_t out_packet;
    logic [IQ_IDX:0] count;
    modport slave (
        input  in_valid, in_packet, out_ready,
        output in_ready, out_valid, out_packet, count
    );
    modport master (
        output in_valid, in_packet, out_ready,
        input  in_ready, out_valid, out_packet, count
    );
endinterface

// File: rtl/inst_queue.sv
// inst_queue: circular packet buffer between fetch and decode with show-ahead head read and flush
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int IQ_DEPTH = IQ_DEPTH_DEF
) (
    input logic          clk,
    input logic          rst,
    input logic          flush,
    inst_queue_if.slave  q
);
    localparam int IDX = $clog2(IQ_DEPTH);
    logic [IDX:0]  head_q, head_d, tail_q, tail_d;
    fetch_packet_t mem_q [IQ_DEPTH];
    logic          empty, full, push, pop;
    assign empty = head_q == tail_q;
    assign full  = (head_q[IDX-1:0] == tail_q[IDX-1:0]) && (head_q[IDX] != tail_q[IDX]);
    assign q.in_ready   = !full;
    assign q.out_valid  = !empty && !flush;
    assign q.out_packet = mem_q[head_q[IDX-1:0]];
    assign q.count      = tail_q - head_q;
    assign push = q.in_valid && !full && !flush;
    assign pop  = q.out_valid && q.out_ready;
    // Depth is a power of two, so a plain increment wraps the index and toggles the wrap bit.
    always_comb begin
        head_d = flush ? '0 : pop  ? head_q + 1'b1 : head_q;
        tail_d = flush ? '0 : push ? tail_q + 1'b1 : tail_q;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q[IDX-1:0]] <= q.in_packet;
    end
    a_no_push_full:  assert property (@(posedge clk) disable iff (!rst) !(push && full));
    a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst) !(pop && empty));
    a_count_bound:   assert property (@(posedge clk) disable iff (!rst) q.count <= IQ_DEPTH);
endmodule
